// File: rtl/reg_4b.sv
// reg_4b: parallel-load data register with load enable and asynchronous clear.
// Holds a WIDTH-bit value. It loads din on a rising clk edge when ld is high.
// While rst is high it is forced to RESET_VALUE. dOut comes straight from the flops.
module reg_4b #(
  parameter int unsigned           WIDTH       = 4,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dOut
);

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;

  // Next value: capture din when ld is high, otherwise recirculate the stored value.
  always_comb begin
    data_next = data_reg;
    if (ld) begin
      data_next = din;
    end
  end

  // Storage flops. rst is asynchronous, takes priority and clears without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= RESET_VALUE;
    end else begin
      data_reg <= data_next;
    end
  end

  assign dOut = data_reg;

endmodule

// File: tb/tb_reg_4b.sv
// Directed testbench for reg_4b: default 4-bit instance plus an 8-bit, 0xA5-reset instance.
module tb_reg_4b;

  logic       clk;
  logic       rst;
  logic       ld;
  logic [3:0] din;
  logic [3:0] dout;

  logic       rst8;
  logic       ld8;
  logic [7:0] din8;
  logic [7:0] dout8;

  int n_cmp;
  int n_bad;

  reg_4b dut (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld),
    .din  (din),
    .dOut (dout)
  );

  reg_4b #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
    .clk  (clk),
    .rst  (rst8),
    .ld   (ld8),
    .din  (din8),
    .dOut (dout8)
  );

  // 10 ns period, first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h at %0t", tag, obs, $time);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    ld    = 1'b0;
    din   = 4'b0000;
    rst8  = 1'b0;
    ld8   = 1'b0;
    din8  = 8'h00;

    // Power-up load: drive at 10 ns, captured at the 15 ns edge.
    @(negedge clk);
    ld  = 1'b1;
    din = 4'b0001;
    @(posedge clk); #1;
    check_val("powerup_load", {28'd0, dout}, 32'h1);

    // Hold for 200 ns with ld low; din changes are ignored.
    @(negedge clk);
    ld  = 1'b0;
    din = 4'b1110;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check_val("hold_after_load", {28'd0, dout}, 32'h1);
    end

    // Load 1010. Then move din mid-cycle with ld high: dOut must not change before the edge.
    @(negedge clk);
    ld  = 1'b1;
    din = 4'b1010;
    @(posedge clk); #1;
    check_val("load_1010", {28'd0, dout}, 32'hA);
    @(negedge clk);
    din = 4'b0101;
    #1;
    check_val("no_comb_path", {28'd0, dout}, 32'hA);
    ld  = 1'b0;
    din = 4'b1010;
    @(posedge clk); #1;
    check_val("hold_1010", {28'd0, dout}, 32'hA);

    // Async reset between edges, checked before the next edge.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("async_reset", {28'd0, dout}, 32'h0);
    ld  = 1'b1;
    din = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_val("reset_held_ld1", {28'd0, dout}, 32'h0);
    end

    // Reset vs load collision: reset wins, the load is not replayed.
    @(negedge clk);
    din = 4'b0110;
    @(posedge clk); #1;
    check_val("collision_rst_wins", {28'd0, dout}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_drop_no_edge", {28'd0, dout}, 32'h0);
    @(posedge clk); #1;
    check_val("load_after_rst", {28'd0, dout}, 32'h6);

    // Back-to-back loads, one value per cycle, then hold.
    @(negedge clk);
    din = 4'b0011;
    @(posedge clk); #1;
    check_val("b2b_0011", {28'd0, dout}, 32'h3);
    @(negedge clk);
    din = 4'b1100;
    @(posedge clk); #1;
    check_val("b2b_1100", {28'd0, dout}, 32'hC);
    @(negedge clk);
    din = 4'b1111;
    @(posedge clk); #1;
    check_val("b2b_1111", {28'd0, dout}, 32'hF);
    @(negedge clk);
    ld  = 1'b0;
    din = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("b2b_hold", {28'd0, dout}, 32'hF);
    end

    // Parameterised instance: reset value 0xA5, then load 0x3C.
    @(negedge clk);
    #1;
    rst8 = 1'b1;
    #1;
    check_val("p8_async_reset", {24'd0, dout8}, 32'hA5);
    ld8  = 1'b1;
    din8 = 8'h3C;
    @(posedge clk); #1;
    check_val("p8_reset_wins", {24'd0, dout8}, 32'hA5);
    @(negedge clk);
    rst8 = 1'b0;
    @(posedge clk); #1;
    check_val("p8_load_3c", {24'd0, dout8}, 32'h3C);
    @(negedge clk);
    ld8  = 1'b0;
    din8 = 8'hFF;
    @(posedge clk); #1;
    check_val("p8_hold_3c", {24'd0, dout8}, 32'h3C);
    @(negedge clk);
    #2;
    rst8 = 1'b1;
    #1;
    check_val("p8_reset_again", {24'd0, dout8}, 32'hA5);
    rst8 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
